// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RAM arbiter state encodings, port owner IDs
// and the default RAM access latency.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    localparam int RAM_LAT_DEF = 1;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port I/D RAM between the
// instruction-fetch and load/store paths, with a fixed access latency.
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = RAM_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(RAM_LAT - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [CW-1:0] lat_cnt_q;
    port_t         owner_q;
    port_t         last_q;
    port_t         grant;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] ls_rdata_q;
    logic          any_req;
    logic          lat_done;

    assign any_req  = if_req | ls_req;
    assign lat_done = (lat_cnt_q == '0);

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant = PORT_IF;
        if (if_req && ls_req) begin
            grant = (last_q == PORT_IF) ? PORT_LS : PORT_IF;
        end else if (ls_req) begin
            grant = PORT_LS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (lat_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_q  <= '0;
            owner_q    <= PORT_IF;
            last_q     <= PORT_LS;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= grant;
                        lat_cnt_q <= LAT_INIT;
                        if (grant == PORT_LS) begin
                            we_q    <= ls_we;
                            addr_q  <= ls_addr;
                            wdata_q <= ls_wdata;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_done) begin
                        if (!we_q && owner_q == PORT_IF) if_rdata_q <= ram_rdata;
                        if (!we_q && owner_q == PORT_LS) ls_rdata_q <= ram_rdata;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                RESP: last_q <= owner_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if_done   = 1'b0;
        ls_done   = 1'b0;
        unique case (state_q)
            ACCESS: begin
                ram_cs    = 1'b1;
                ram_we    = we_q;
                ram_oe    = ~we_q;
                ram_addr  = addr_q;
                ram_wdata = we_q ? wdata_q : '0;
            end
            RESP: begin
                if_done = (owner_q == PORT_IF);
                ls_done = (owner_q == PORT_LS);
            end
            default: ;
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters: the instruction-fetch path (IF) and the load/store path (LS).
- Sequences every RAM access, driving ram_cs/ram_we/ram_oe for a fixed number of cycles and then returning a one-cycle done pulse with the read data.
- Sits between the CPU control/datapath and the RAM. The controller FSM waits on if_done/ls_done instead of assuming single-cycle RAM.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RAM_LAT, 1, cycles ram_cs is held per access (>=1); read data is valid on the last of these cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request (read only).
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word.
- if_done  out  1  one-cycle completion pulse for IF.
- ls_req  in  1  load/store request.
- ls_we  in  1  1=store, 0=load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_rdata  out  DW  loaded word.
- ls_done  out  1  one-cycle completion pulse for LS.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, lat_cnt=0, last_grant=LS (so IF wins the first tie).
  - All outputs 0, including if_rdata/ls_rdata.
  - Reset asserted mid-access aborts the access; no done pulse is issued for it.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req is high at the edge, latch the grant (owner), addr, we and wdata, set lat_cnt=RAM_LAT-1, go to ACCESS. Otherwise stay.
  - ACCESS: ram_cs=1 and ram_addr=latched addr.
    - Read: ram_oe=1, ram_we=0.
    - Write: ram_we=1, ram_oe=0, ram_wdata=latched wdata.
    - When lat_cnt==0: capture ram_rdata into the owner's rdata register (reads only), go to RESP. Otherwise decrement lat_cnt.
  - RESP: ram_cs/ram_we/ram_oe=0. The owner's done=1 for exactly this cycle. Set last_grant=owner, go to IDLE. Requests are not sampled in RESP.
- Arbitration (IDLE only):
  - Only one req high: grant it.
  - Both high: grant the port that is not last_grant (round-robin).
  - LS cannot be starved by back-to-back fetches.
- Handshake:
  - Requester holds req and its addr/data stable until it sees done.
  - Inputs are latched at grant, so changes after grant are ignored.
  - A requester that keeps req high in the cycle after done is treated as issuing a new request.
  - Dropping req during ACCESS does not cancel the access; done is still pulsed.
- Latency: req sampled in IDLE at edge k gives ACCESS for cycles k+1..k+RAM_LAT and done in cycle k+RAM_LAT+1. Minimum turnaround is RAM_LAT+2 cycles per access.
- if_rdata/ls_rdata hold their value until the next completed read for that port. A store never changes ls_rdata.
- ram_addr/ram_wdata are 0 outside ACCESS.
- if_done and ls_done are never high in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - the arbiter state encodings IDLE/ACCESS/RESP;
  - the owner IDs PORT_IF=0, PORT_LS=1;
  - default RAM_LAT.
- No sub-module; the round-robin pick is a few lines inline.

Test Plan:
- IF read alone, RAM_LAT=1, if_addr=0x10, RAM holds 0x00A00093: ram_cs/ram_oe high for 1 cycle, if_done 2 cycles after req, if_rdata=0x00A00093.
- LS store, ls_addr=0x40, ls_wdata=0xDEADBEEF: ram_we=1 and ram_oe=0 during ACCESS, ls_done pulses, subsequent LS load of 0x40 returns 0xDEADBEEF, ls_rdata unchanged by the store.
- Both requesting continuously from reset: grants alternate IF, LS, IF, LS; no done overlap; each grant is 3 cycles apart with RAM_LAT=1.
- RAM_LAT=3, IF read: ram_cs high exactly 3 cycles, data captured on the 3rd cycle, if_done in cycle 4 after sampling.
- ls_req dropped and ls_addr changed during ACCESS: access completes to the original address, ls_done still pulses.
- rst asserted in the middle of ACCESS: outputs go to 0 immediately; no done; after release, an IF+LS tie grants IF first.
